// File: rtl/rv32i_types.sv
// Shared types for the instruction/data memory arbiter: FSM states and the pending-request payload.
package rv32i_types;

  localparam int unsigned ARB_ADDR_W = 32;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_MASK_W = ARB_DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [ARB_ADDR_W-1:0] addr;
    logic [ARB_MASK_W-1:0] rmask;
    logic [ARB_MASK_W-1:0] wmask;
    logic [ARB_DATA_W-1:0] wdata;
  } arb_req_t;

  // A request exists only when at least one mask bit is set.
  function automatic logic req_valid(arb_req_t r);
    return (|r.rmask) || (|r.wmask);
  endfunction

endpackage

// File: rtl/mem_req_buf.sv
// One-entry pending buffer for a requester; holds the request until the downstream response clears it.
module mem_req_buf
  import rv32i_types::*;
(
  input  logic     clk,
  input  logic     rst_n,
  input  arb_req_t req_i,
  input  logic     clr_i,
  output logic     full_o,
  output arb_req_t buf_o
);

  logic     full_q;
  arb_req_t buf_q;
  logic     load;

  // A full buffer only accepts a new request in the cycle it is being cleared.
  assign load = req_valid(req_i) && (!full_q || clr_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end else if (load) begin
      full_q <= 1'b1;
      buf_q  <= req_i;
    end else if (clr_i) begin
      full_q <= 1'b0;
      buf_q  <= '0;
    end
  end

  assign full_o = full_q;
  assign buf_o  = buf_q;

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates instruction and data requests onto one downstream memory port.
// Define ARB_RR_EN for round-robin arbitration; default is fixed priority with dmem winning.
module mem_arbiter
  import rv32i_types::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   imem_addr,
  input  logic [DATA_W/8-1:0] imem_rmask,
  output logic [DATA_W-1:0]   imem_rdata,
  output logic                imem_resp,
  input  logic [ADDR_W-1:0]   dmem_addr,
  input  logic [DATA_W/8-1:0] dmem_rmask,
  input  logic [DATA_W/8-1:0] dmem_wmask,
  input  logic [DATA_W-1:0]   dmem_wdata,
  output logic [DATA_W-1:0]   dmem_rdata,
  output logic                dmem_resp,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W/8-1:0] mem_rmask,
  output logic [DATA_W/8-1:0] mem_wmask,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_resp
);

  localparam int unsigned MASK_W = DATA_W / 8;

  arb_state_t state_q, state_d;
  arb_req_t   ireq, dreq, ibuf, dbuf;
  logic       ifull, dfull, iclr, dclr;
  logic       issue_i, issue_d, pick_d;

  logic [ADDR_W-1:0] mem_addr_q;
  logic [MASK_W-1:0] mem_rmask_q, mem_wmask_q;
  logic [DATA_W-1:0] mem_wdata_q;

  always_comb begin
    ireq       = '0;
    ireq.addr  = ARB_ADDR_W'(imem_addr);
    ireq.rmask = ARB_MASK_W'(imem_rmask);
    dreq       = '0;
    dreq.addr  = ARB_ADDR_W'(dmem_addr);
    dreq.rmask = ARB_MASK_W'(dmem_rmask);
    dreq.wmask = ARB_MASK_W'(dmem_wmask);
    dreq.wdata = ARB_DATA_W'(dmem_wdata);
  end

  mem_req_buf u_ibuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (ireq),
    .clr_i  (iclr),
    .full_o (ifull),
    .buf_o  (ibuf)
  );

  mem_req_buf u_dbuf (
    .clk    (clk),
    .rst_n  (rst_n),
    .req_i  (dreq),
    .clr_i  (dclr),
    .full_o (dfull),
    .buf_o  (dbuf)
  );

`ifdef ARB_RR_EN
  // Set when dmem was the last requester issued downstream.
  logic last_d_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (issue_d) begin
      last_d_q <= 1'b1;
    end else if (issue_i) begin
      last_d_q <= 1'b0;
    end
  end

  assign pick_d = ~last_d_q;
`else
  assign pick_d = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    issue_i    = 1'b0;
    issue_d    = 1'b0;
    iclr       = 1'b0;
    dclr       = 1'b0;
    imem_resp  = 1'b0;
    dmem_resp  = 1'b0;
    imem_rdata = '0;
    dmem_rdata = '0;
    unique case (state_q)
      IDLE: begin
        if (ifull && dfull) begin
          issue_d = pick_d;
          issue_i = ~pick_d;
        end else begin
          issue_d = dfull;
          issue_i = ifull;
        end
      end
      BUSY_I: begin
        if (mem_resp) begin
          imem_resp  = 1'b1;
          imem_rdata = mem_rdata;
          iclr       = 1'b1;
          issue_d    = dfull;
          state_d    = IDLE;
        end
      end
      BUSY_D: begin
        if (mem_resp) begin
          dmem_resp  = 1'b1;
          dmem_rdata = mem_rdata;
          dclr       = 1'b1;
          issue_i    = ifull;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (issue_i) state_d = BUSY_I;
    if (issue_d) state_d = BUSY_D;
  end

  // Masks pulse for one cycle after an issue; address and data hold until the next issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_addr_q  <= '0;
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_rmask_q <= '0;
      mem_wmask_q <= '0;
      if (issue_i) begin
        mem_addr_q  <= ADDR_W'(ibuf.addr);
        mem_rmask_q <= MASK_W'(ibuf.rmask);
        mem_wmask_q <= MASK_W'(ibuf.wmask);
        mem_wdata_q <= DATA_W'(ibuf.wdata);
      end else if (issue_d) begin
        mem_addr_q  <= ADDR_W'(dbuf.addr);
        mem_wdata_q <= DATA_W'(dbuf.wdata);
        if (|dbuf.wmask) begin
          mem_wmask_q <= MASK_W'(dbuf.wmask);
        end else begin
          mem_rmask_q <= MASK_W'(dbuf.rmask);
        end
      end
    end
  end

  assign mem_addr  = mem_addr_q;
  assign mem_rmask = mem_rmask_q;
  assign mem_wmask = mem_wmask_q;
  assign mem_wdata = mem_wdata_q;

endmodule
